// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared types and helpers for the parity-protected storage controller.
//   state_t      : scrub engine state {IDLE, SCRUB}
//   even_parity  : XOR-reduction of a zero-extended vector
//   STORE_W      : stored entry width (data + one parity bit) at default DATA_W
// -----------------------------------------------------------------------------
package parity_pkg;

    localparam int unsigned DEF_DATA_W         = 4;
    localparam int unsigned DEF_DEPTH          = 16;
    localparam int unsigned DEF_SCRUB_INTERVAL = 64;
    localparam int unsigned DEF_ERR_CNT_W      = 8;
    localparam int unsigned STORE_W            = DEF_DATA_W + 1;

    // Widest data word even_parity accepts; zero padding does not change parity.
    localparam int unsigned PAR_MAX_W = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } state_t;

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] i_vec);
        return ^i_vec;
    endfunction

endpackage

// File: rtl/parity_calc.sv
// -----------------------------------------------------------------------------
// parity_calc
// Combinational even-parity generate/check: o_par_c = ^i_data ^ i_par.
//   On the write path i_par is the inject hook, so o_par_c is the parity bit
//   to store. On the check path i_par is the stored parity bit, so o_par_c is
//   the entry error flag (1 = error).
// Ports:
//   i_data  [DATA_W]  data word
//   i_par   1         parity bit / inject bit
//   o_par_c 1         combined parity (combinational)
// -----------------------------------------------------------------------------
module parity_calc
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_par,
    output logic              o_par_c
);

    assign o_par_c = even_parity(PAR_MAX_W'(i_data)) ^ i_par;

endmodule

// File: rtl/parity_scrub_ctrl.sv
// -----------------------------------------------------------------------------
// parity_scrub_ctrl
// Parity-protected register storage with host write/read ports and a
// background scrub engine that periodically re-checks every entry.
// Single storage port arbitration: write > host read > scrub.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_wr_valid/o_wr_ready             host write (never stalls)
//   i_wr_addr, i_wr_data, i_err_inject write address/data, parity-invert hook
//   i_rd_valid/o_rd_ready, i_rd_addr  host read (ready = no write this cycle)
//   o_rd_resp_valid/_data/_err        read response, one cycle after accept
//   i_scrub_en, o_scrub_busy          scrub enable, pass in progress
//   o_err_count                       saturating total error count
//   o_err_addr, o_err_irq, i_irq_clr  first-error address, sticky irq, clear
// -----------------------------------------------------------------------------
module parity_scrub_ctrl
    import parity_pkg::*;
#(
    parameter  int unsigned DATA_W         = DEF_DATA_W,
    parameter  int unsigned DEPTH          = DEF_DEPTH,
    parameter  int unsigned SCRUB_INTERVAL = DEF_SCRUB_INTERVAL,
    parameter  int unsigned ERR_CNT_W      = DEF_ERR_CNT_W,
    localparam int unsigned AW             = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]    i_wr_data,
    input  logic                 i_err_inject,
    input  logic                 i_rd_valid,
    output logic                 o_rd_ready,
    input  logic [AW-1:0]        i_rd_addr,
    output logic                 o_rd_resp_valid,
    output logic [DATA_W-1:0]    o_rd_resp_data,
    output logic                 o_rd_resp_err,
    input  logic                 i_scrub_en,
    output logic                 o_scrub_busy,
    output logic [ERR_CNT_W-1:0] o_err_count,
    output logic [AW-1:0]        o_err_addr,
    output logic                 o_err_irq,
    input  logic                 i_irq_clr
);

    localparam int unsigned ST_W  = DATA_W + 1;
    localparam int unsigned CNT_W = $clog2(SCRUB_INTERVAL);

    // Entry layout: {parity, data}
    logic [ST_W-1:0]      r_mem [DEPTH];

    state_t               r_state;
    logic [CNT_W-1:0]     r_interval;
    logic [AW-1:0]        r_scrub_ptr;
    logic                 r_scrub_busy;

    logic                 r_rd_resp_valid;
    logic [DATA_W-1:0]    r_rd_resp_data;
    logic                 r_rd_resp_err;

    logic [ERR_CNT_W-1:0] r_err_count;
    logic [AW-1:0]        r_err_addr;
    logic                 r_err_irq;

    logic                 w_rd_fire;
    logic                 w_scrub_fire;
    logic [AW-1:0]        w_chk_addr;
    logic [ST_W-1:0]      w_chk_entry;
    logic                 w_chk_err;
    logic                 w_err_evt;
    logic                 w_wr_par;

    // Port arbitration: a write blocks both the host read and the scrub check.
    assign w_rd_fire    = i_rd_valid && !i_wr_valid;
    assign w_scrub_fire = (r_state == SCRUB) && !i_wr_valid && !w_rd_fire;
    assign w_chk_addr   = w_rd_fire ? i_rd_addr : r_scrub_ptr;
    assign w_chk_entry  = r_mem[w_chk_addr];
    assign w_err_evt    = (w_rd_fire || w_scrub_fire) && w_chk_err;

    parity_calc #(.DATA_W(DATA_W)) u_wr_par (
        .i_data  (i_wr_data),
        .i_par   (i_err_inject),
        .o_par_c (w_wr_par)
    );

    parity_calc #(.DATA_W(DATA_W)) u_chk_par (
        .i_data  (w_chk_entry[DATA_W-1:0]),
        .i_par   (w_chk_entry[DATA_W]),
        .o_par_c (w_chk_err)
    );

    // Storage array; a write always regenerates parity, repairing bad entries.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_valid) begin
            r_mem[i_wr_addr] <= {w_wr_par, i_wr_data};
        end
    end

    // Host read response
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_resp_valid <= 1'b0;
            r_rd_resp_data  <= '0;
            r_rd_resp_err   <= 1'b0;
        end else begin
            r_rd_resp_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_resp_data <= w_chk_entry[DATA_W-1:0];
                r_rd_resp_err  <= w_chk_err;
            end
        end
    end

    // Error log; a new error outranks irq_clr and re-captures the address.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_count <= '0;
            r_err_addr  <= '0;
            r_err_irq   <= 1'b0;
        end else if (w_err_evt) begin
            if (r_err_count != {ERR_CNT_W{1'b1}}) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
            if (!r_err_irq || i_irq_clr) begin
                r_err_addr <= w_chk_addr;
            end
            r_err_irq <= 1'b1;
        end else if (i_irq_clr) begin
            r_err_irq <= 1'b0;
        end
    end

    // Scrub engine: interval counter in IDLE, stall-able walk in SCRUB.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_interval   <= '0;
            r_scrub_ptr  <= '0;
            r_scrub_busy <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!i_scrub_en) begin
                        r_interval <= '0;
                    end else if (r_interval == CNT_W'(SCRUB_INTERVAL - 1)) begin
                        r_interval   <= '0;
                        r_scrub_ptr  <= '0;
                        r_scrub_busy <= 1'b1;
                        r_state      <= SCRUB;
                    end else begin
                        r_interval <= r_interval + CNT_W'(1);
                    end
                end
                SCRUB: begin
                    if (w_scrub_fire) begin
                        if (r_scrub_ptr == AW'(DEPTH - 1)) begin
                            r_scrub_ptr  <= '0;
                            r_scrub_busy <= 1'b0;
                            r_state      <= IDLE;
                        end else begin
                            r_scrub_ptr <= r_scrub_ptr + AW'(1);
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_scrub_busy <= 1'b0;
                end
            endcase
        end
    end

    assign o_wr_ready      = 1'b1;
    assign o_rd_ready      = !i_wr_valid;
    assign o_rd_resp_valid = r_rd_resp_valid;
    assign o_rd_resp_data  = r_rd_resp_data;
    assign o_rd_resp_err   = r_rd_resp_err;
    assign o_scrub_busy    = r_scrub_busy;
    assign o_err_count     = r_err_count;
    assign o_err_addr      = r_err_addr;
    assign o_err_irq       = r_err_irq;

endmodule

// File: tb/tb_parity_scrub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parity_scrub_ctrl
// Self-checking bench: directed vector table, hand-written scrub/saturation
// sequences, and randomized traffic against a behavioural reference model
// that tracks each entry as {data, corrupted?} rather than parity bits.
// -----------------------------------------------------------------------------
module tb_parity_scrub_ctrl;

    localparam int unsigned DW  = 4;
    localparam int unsigned DEP = 16;
    localparam int unsigned AW  = 4;
    localparam int unsigned SI  = 64;
    localparam int unsigned EW  = 8;
    localparam int          CNT_MAX = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid, wr_ready, err_inject;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_resp_valid, rd_resp_err;
    logic [DW-1:0] rd_resp_data;
    logic          scrub_en, scrub_busy;
    logic [EW-1:0] err_count;
    logic [AW-1:0] err_addr;
    logic          err_irq, irq_clr;

    always #5 clk = ~clk;

    parity_scrub_ctrl dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_wr_valid      (wr_valid),
        .o_wr_ready      (wr_ready),
        .i_wr_addr       (wr_addr),
        .i_wr_data       (wr_data),
        .i_err_inject    (err_inject),
        .i_rd_valid      (rd_valid),
        .o_rd_ready      (rd_ready),
        .i_rd_addr       (rd_addr),
        .o_rd_resp_valid (rd_resp_valid),
        .o_rd_resp_data  (rd_resp_data),
        .o_rd_resp_err   (rd_resp_err),
        .i_scrub_en      (scrub_en),
        .o_scrub_busy    (scrub_busy),
        .o_err_count     (err_count),
        .o_err_addr      (err_addr),
        .o_err_irq       (err_irq),
        .i_irq_clr       (irq_clr)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] m_data [DEP];
    bit            m_bad  [DEP];
    int            m_cnt;
    bit            m_irq;
    int            m_eaddr;
    bit            m_busy;
    int            m_ptr;
    int            m_icnt;
    bit            m_rv;
    logic [DW-1:0] m_rdata;
    bit            m_rerr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) begin
            m_data[i] = '0;
            m_bad[i]  = 1'b0;
        end
        m_cnt = 0; m_irq = 1'b0; m_eaddr = 0;
        m_busy = 1'b0; m_ptr = 0; m_icnt = 0;
        m_rv = 1'b0; m_rdata = '0; m_rerr = 1'b0;
    endtask

    // One clock of behaviour, applied from the rules rather than from RTL structure.
    task automatic model_step(input bit r, input bit wr, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input bit inj, input bit rd,
                              input logic [AW-1:0] ra, input bit en, input bit clr);
        bit rd_fire, sc, err;
        int a;
        if (r) begin
            model_reset();
            return;
        end
        rd_fire = rd && !wr;
        sc      = m_busy && !wr && !rd_fire;
        m_rv    = rd_fire;
        if (rd_fire) begin
            m_rdata = m_data[ra];
            m_rerr  = m_bad[ra];
        end
        a   = rd_fire ? int'(ra) : m_ptr;
        err = (rd_fire || sc) && m_bad[a];
        if (err) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (!m_irq || clr) m_eaddr = a;
            m_irq = 1'b1;
        end else if (clr) begin
            m_irq = 1'b0;
        end
        if (!m_busy) begin
            if (!en) m_icnt = 0;
            else if (m_icnt == SI - 1) begin
                m_icnt = 0; m_ptr = 0; m_busy = 1'b1;
            end else m_icnt++;
        end else if (sc) begin
            if (m_ptr == DEP - 1) begin
                m_ptr = 0; m_busy = 1'b0;
            end else m_ptr++;
        end
        if (wr) begin
            m_data[wa] = wd;
            m_bad[wa]  = inj;
        end
    endtask

    task automatic step(input bit r, input bit wr, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input bit inj, input bit rd,
                        input logic [AW-1:0] ra, input bit en, input bit clr);
        @(negedge clk);
        rst = r; wr_valid = wr; wr_addr = wa; wr_data = wd; err_inject = inj;
        rd_valid = rd; rd_addr = ra; scrub_en = en; irq_clr = clr;
        #1;
        chk("wr_ready", 32'(wr_ready), 32'd1);
        chk("rd_ready", 32'(rd_ready), 32'(!wr));
        model_step(r, wr, wa, wd, inj, rd, ra, en, clr);
        @(posedge clk);
        #1;
        chk("rd_resp_valid", 32'(rd_resp_valid), 32'(m_rv));
        if (m_rv) begin
            chk("rd_resp_data", 32'(rd_resp_data), 32'(m_rdata));
            chk("rd_resp_err", 32'(rd_resp_err), 32'(m_rerr));
        end
        chk("scrub_busy", 32'(scrub_busy), 32'(m_busy));
        chk("err_count", 32'(err_count), 32'(m_cnt));
        chk("err_addr", 32'(err_addr), 32'(m_eaddr));
        chk("err_irq", 32'(err_irq), 32'(m_irq));
    endtask

    task automatic do_rst();
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic do_wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input bit inj, input bit en);
        step(1'b0, 1'b1, wa, wd, inj, 1'b0, 4'd0, en, 1'b0);
    endtask

    task automatic do_rd(input logic [AW-1:0] ra, input bit en, input bit clr);
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, ra, en, clr);
    endtask

    task automatic do_idle(input bit en, input bit clr);
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, en, clr);
    endtask

    // Idle with scrub enabled until scrub_busy equals want, bounded by max steps.
    task automatic run_until(input bit want, input int max, output int n);
        n = 0;
        do begin
            do_idle(1'b1, 1'b0);
            n++;
        end while (scrub_busy !== want && n < max);
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            inj;
        bit            rd;
        logic [AW-1:0] ra;
        bit            ev;
        logic [DW-1:0] ed;
        bit            ee;
        int            ec;
        bit            ei;
        logic [AW-1:0] ea;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int n;
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; err_inject = 1'b0;
        rd_valid = 1'b0; rd_addr = '0; scrub_en = 1'b0; irq_clr = 1'b0;
        model_reset();

        //            wr    wa     wd       inj   rd    ra     ev    ed       ee    ec ei    ea
        tbl[0] = '{1'b1, 4'd3, 4'b1011, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0,    1'b0, 0, 1'b0, 4'd0};
        tbl[1] = '{1'b0, 4'd0, 4'd0,    1'b0, 1'b1, 4'd3, 1'b1, 4'b1011, 1'b0, 0, 1'b0, 4'd0};
        tbl[2] = '{1'b1, 4'd5, 4'b0001, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0,    1'b0, 0, 1'b0, 4'd0};
        tbl[3] = '{1'b0, 4'd0, 4'd0,    1'b0, 1'b1, 4'd5, 1'b1, 4'b0001, 1'b1, 1, 1'b1, 4'd5};
        tbl[4] = '{1'b1, 4'd9, 4'b0110, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0,    1'b0, 1, 1'b1, 4'd5};
        tbl[5] = '{1'b0, 4'd0, 4'd0,    1'b0, 1'b1, 4'd9, 1'b1, 4'b0110, 1'b1, 2, 1'b1, 4'd5};
        tbl[6] = '{1'b1, 4'd3, 4'b0000, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0,    1'b0, 2, 1'b1, 4'd5};
        tbl[7] = '{1'b0, 4'd0, 4'd0,    1'b0, 1'b1, 4'd3, 1'b1, 4'b0000, 1'b0, 2, 1'b1, 4'd5};
        tbl[8] = '{1'b1, 4'd5, 4'b0001, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0,    1'b0, 2, 1'b1, 4'd5};
        tbl[9] = '{1'b0, 4'd0, 4'd0,    1'b0, 1'b1, 4'd5, 1'b1, 4'b0001, 1'b0, 2, 1'b1, 4'd5};

        // Reset state and all-zero contents
        do_rst();
        do_rst();
        for (int a = 0; a < DEP; a++) begin
            do_rd(AW'(a), 1'b0, 1'b0);
            chk("init_rd_data", 32'(rd_resp_data), 32'd0);
            chk("init_rd_err", 32'(rd_resp_err), 32'd0);
        end
        chk("init_err_count", 32'(err_count), 32'd0);
        chk("init_err_irq", 32'(err_irq), 32'd0);

        // Directed vector table (scrub disabled)
        for (int i = 0; i < 10; i++) begin
            step(1'b0, tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].inj,
                 tbl[i].rd, tbl[i].ra, 1'b0, 1'b0);
            chk("tbl_valid", 32'(rd_resp_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk("tbl_data", 32'(rd_resp_data), 32'(tbl[i].ed));
                chk("tbl_err", 32'(rd_resp_err), 32'(tbl[i].ee));
            end
            chk("tbl_count", 32'(err_count), 32'(tbl[i].ec));
            chk("tbl_irq", 32'(err_irq), 32'(tbl[i].ei));
            chk("tbl_eaddr", 32'(err_addr), 32'(tbl[i].ea));
        end

        // Scrub pass timing and detection of a single bad entry
        do_rst();
        do_wr(4'd12, 4'b0011, 1'b1, 1'b0);
        run_until(1'b1, 100, n);
        chk("scrub_start_cycles", 32'(n), 32'd64);
        run_until(1'b0, 40, n);
        chk("scrub_pass_len", 32'(n), 32'd16);
        chk("scrub_count1", 32'(err_count), 32'd1);
        chk("scrub_eaddr1", 32'(err_addr), 32'd12);
        do_idle(1'b1, 1'b1);
        chk("irq_cleared", 32'(err_irq), 32'd0);
        run_until(1'b1, 100, n);
        chk("scrub_restart_cycles", 32'(n), 32'd63);
        run_until(1'b0, 40, n);
        chk("scrub_count2", 32'(err_count), 32'd2);
        chk("scrub_eaddr2", 32'(err_addr), 32'd12);
        chk("scrub_irq2", 32'(err_irq), 32'd1);

        // Scrub stalled by continuous writes, then resumes at the same entry
        do_rst();
        do_wr(4'd15, 4'b0111, 1'b1, 1'b0);
        run_until(1'b1, 100, n);
        chk("stall_start_cycles", 32'(n), 32'd64);
        for (int k = 0; k < 5; k++) do_idle(1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 4'd0, 4'h3, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0);
        end
        chk("stall_busy", 32'(scrub_busy), 32'd1);
        chk("stall_count", 32'(err_count), 32'd0);
        run_until(1'b0, 40, n);
        chk("stall_remaining", 32'(n), 32'd11);
        chk("stall_count_after", 32'(err_count), 32'd1);
        chk("stall_eaddr", 32'(err_addr), 32'd15);

        // Counter saturation and irq_clr vs. new error
        do_rst();
        do_wr(4'd1, 4'b1000, 1'b1, 1'b0);
        do_wr(4'd6, 4'b1100, 1'b1, 1'b0);
        for (int k = 0; k < 300; k++) do_rd(4'd1, 1'b0, 1'b0);
        chk("sat_count", 32'(err_count), 32'd255);
        chk("sat_irq", 32'(err_irq), 32'd1);
        do_idle(1'b0, 1'b1);
        chk("clr_alone", 32'(err_irq), 32'd0);
        chk("clr_keeps_count", 32'(err_count), 32'd255);
        do_rd(4'd1, 1'b0, 1'b0);
        chk("rearm_eaddr", 32'(err_addr), 32'd1);
        do_rd(4'd6, 1'b0, 1'b1);
        chk("clr_with_err_irq", 32'(err_irq), 32'd1);
        chk("clr_with_err_eaddr", 32'(err_addr), 32'd6);

        // Randomized traffic against the reference model
        do_rst();
        for (int c = 0; c < 2500; c++) begin
            step(1'($urandom_range(0, 499) == 0),
                 1'($urandom_range(0, 3) == 0),
                 AW'($urandom_range(0, DEP - 1)),
                 DW'($urandom_range(0, 15)),
                 1'($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 9) < 3),
                 AW'($urandom_range(0, DEP - 1)),
                 1'($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
